// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I decode/issue stage feeding the ALU through one ID/EX register
// Decodes OP, OP-IMM, LUI and AUIPC into {Ainv,Binv,ALUsel} and operands under valid/ready.
module alu_issue_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_rs1_val,
    input  logic [31:0]      in_rs2_val,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      SrcA,
    output logic [31:0]      SrcB,
    output logic             Ainv,
    output logic             Binv,
    output logic [2:0]       ALUsel,
    output logic [4:0]       out_rd,
    output logic             out_we,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issue_count,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [4:0] CODE_AND = 5'b00000;
    localparam logic [4:0] CODE_OR  = 5'b00001;
    localparam logic [4:0] CODE_ADD = 5'b00010;
    localparam logic [4:0] CODE_SUB = 5'b01010;
    localparam logic [4:0] CODE_XOR = 5'b00100;
    localparam logic [4:0] CODE_SRA = 5'b00101;
    localparam logic [4:0] CODE_SLL = 5'b00110;
    localparam logic [4:0] CODE_SRL = 5'b00111;
    localparam logic [4:0] CODE_SLT = 5'b01011;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_u;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign rd     = in_instr[11:7];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_u  = {in_instr[31:12], 12'b0};

    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [4:0]  dec_code;
    logic        dec_illegal;

    always_comb begin
        dec_a       = 32'd0;
        dec_b       = 32'd0;
        dec_code    = CODE_ADD;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a = in_rs1_val;
                dec_b = in_rs2_val;
                // funct7 = 0100000 is only meaningful for ADD/SUB and SRL/SRA
                if (!(funct7 == F7_ZERO ||
                      (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
                    dec_illegal = 1'b1;
                end else begin
                    case (funct3)
                        3'b000: dec_code = funct7[5] ? CODE_SUB : CODE_ADD;
                        3'b001: begin
                            dec_code = CODE_SLL;
                            dec_b    = {27'd0, in_rs2_val[4:0]};
                        end
                        3'b010,
                        3'b011: dec_code = CODE_SLT;
                        3'b100: dec_code = CODE_XOR;
                        3'b101: begin
                            dec_code = funct7[5] ? CODE_SRA : CODE_SRL;
                            dec_b    = {27'd0, in_rs2_val[4:0]};
                        end
                        3'b110: dec_code = CODE_OR;
                        default: dec_code = CODE_AND;
                    endcase
                end
            end
            OPC_OP_IMM: begin
                dec_a = in_rs1_val;
                dec_b = imm_i;
                case (funct3)
                    3'b000: dec_code = CODE_ADD;
                    3'b001: begin
                        dec_code    = CODE_SLL;
                        dec_b       = {27'd0, in_instr[24:20]};
                        dec_illegal = (funct7 != F7_ZERO);
                    end
                    3'b010,
                    3'b011: dec_code = CODE_SLT;
                    3'b100: dec_code = CODE_XOR;
                    3'b101: begin
                        dec_code    = funct7[5] ? CODE_SRA : CODE_SRL;
                        dec_b       = {27'd0, in_instr[24:20]};
                        dec_illegal = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
                    end
                    3'b110: dec_code = CODE_OR;
                    default: dec_code = CODE_AND;
                endcase
            end
            OPC_LUI: begin
                dec_a = 32'd0;
                dec_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = in_pc;
                dec_b = imm_u;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal ops issue as a harmless ADD of zeros
        if (dec_illegal) begin
            dec_a    = 32'd0;
            dec_b    = 32'd0;
            dec_code = CODE_ADD;
        end
    end

    logic accept;
    logic handoff;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            SrcA          <= 32'd0;
            SrcB          <= 32'd0;
            Ainv          <= 1'b0;
            Binv          <= 1'b0;
            ALUsel        <= 3'd0;
            out_rd        <= 5'd0;
            out_we        <= 1'b0;
            out_illegal   <= 1'b0;
            issue_count   <= '0;
            illegal_count <= '0;
        end else begin
            // The consumer has already taken the op, so a handoff counts even under flush
            if (handoff) begin
                issue_count <= issue_count + 1'b1;
                if (out_illegal) begin
                    illegal_count <= illegal_count + 1'b1;
                end
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid   <= 1'b1;
                SrcA        <= dec_a;
                SrcB        <= dec_b;
                Ainv        <= dec_code[4];
                Binv        <= dec_code[3];
                ALUsel      <= dec_code[2:0];
                out_rd      <= rd;
                out_we      <= !dec_illegal && (rd != 5'd0);
                out_illegal <= dec_illegal;
            end else if (handoff) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Ainv;
    logic        Binv;
    logic [2:0]  ALUsel;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;
    logic [31:0] issue_count;
    logic [31:0] illegal_count;

    int errors = 0;
    int checks = 0;

    alu_issue_stage #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB),
        .Ainv(Ainv), .Binv(Binv), .ALUsel(ALUsel),
        .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal),
        .issue_count(issue_count), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] pc);
        in_instr   = instr;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
        in_pc      = pc;
    endtask

    function automatic logic [31:0] code();
        return {27'd0, Ainv, Binv, ALUsel};
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_srca", SrcA, 32'd0);
        chk("rst_code", code(), 32'd0);
        chk("rst_issue", issue_count, 32'd0);
        reset = 1'b0;

        // ADD x3,x1,x2
        in_valid = 1'b1;
        drive(r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7, 32'd0);
        tick();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_code", code(), 32'b00010);
        chk("add_srca", SrcA, 32'd5);
        chk("add_srcb", SrcB, 32'd7);
        chk("add_rd", {27'd0, out_rd}, 32'd3);
        chk("add_we", {31'd0, out_we}, 32'd1);
        chk("add_issue0", issue_count, 32'd0);

        // SUB x4,x1,x2
        drive(r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4), 32'd10, 32'd3, 32'd0);
        tick();
        chk("sub_code", code(), 32'b01010);
        chk("sub_issue", issue_count, 32'd1);

        // SRAI x5,x6,4
        drive(i_type({7'b0100000, 5'd4}, 5'd6, 3'b101, 5'd5, 7'b0010011), 32'h80000000, 32'd0, 32'd0);
        tick();
        chk("srai_valid", {31'd0, out_valid}, 32'd1);
        chk("srai_code", code(), 32'b00101);
        chk("srai_srca", SrcA, 32'h80000000);
        chk("srai_srcb", SrcB, 32'd4);
        chk("srai_issue", issue_count, 32'd2);

        // SLL x9,x1,x2 with upper rs2 bits set
        drive(r_type(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd9), 32'd1, 32'hFFFFFF23, 32'd0);
        tick();
        chk("sll_code", code(), 32'b00110);
        chk("sll_srcb", SrcB, 32'd3);

        // ADDI x1,x0,-1
        drive(i_type(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'd0, 32'd0, 32'd0);
        tick();
        chk("addi_code", code(), 32'b00010);
        chk("addi_srcb", SrcB, 32'hFFFFFFFF);
        chk("addi_rd", {27'd0, out_rd}, 32'd1);

        // LUI x2,0xABCDE
        drive(u_type(20'hABCDE, 5'd2, 7'b0110111), 32'd123, 32'd456, 32'h40);
        tick();
        chk("lui_srca", SrcA, 32'd0);
        chk("lui_srcb", SrcB, 32'hABCDE000);

        // AUIPC x7,1 at pc 0x100
        drive(u_type(20'h00001, 5'd7, 7'b0010111), 32'd99, 32'd0, 32'h100);
        tick();
        chk("auipc_srca", SrcA, 32'h100);
        chk("auipc_srcb", SrcB, 32'h1000);
        chk("auipc_code", code(), 32'b00010);
        chk("auipc_issue", issue_count, 32'd6);

        // Stall three cycles with XOR x8 waiting
        out_ready = 1'b0;
        drive(r_type(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd8), 32'hF0, 32'h0F, 32'd0);
        #1;
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_srca", SrcA, 32'h100);
            chk("stall_srcb", SrcB, 32'h1000);
            chk("stall_rd", {27'd0, out_rd}, 32'd7);
            chk("stall_issue", issue_count, 32'd6);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("xor_code", code(), 32'b00100);
        chk("xor_srca", SrcA, 32'hF0);
        chk("xor_srcb", SrcB, 32'h0F);
        chk("xor_rd", {27'd0, out_rd}, 32'd8);
        chk("xor_issue", issue_count, 32'd7);

        // Load opcode is illegal
        drive(i_type(12'd0, 5'd1, 3'b010, 5'd10, 7'b0000011), 32'h55, 32'h66, 32'd0);
        tick();
        chk("ld_illegal", {31'd0, out_illegal}, 32'd1);
        chk("ld_we", {31'd0, out_we}, 32'd0);
        chk("ld_code", code(), 32'b00010);
        chk("ld_srca", SrcA, 32'd0);
        chk("ld_srcb", SrcB, 32'd0);
        chk("ld_rd", {27'd0, out_rd}, 32'd10);
        chk("ld_illcnt", illegal_count, 32'd0);

        // SRL with funct7=0000001 is illegal
        drive(r_type(7'b0000001, 5'd2, 5'd1, 3'b101, 5'd11), 32'h55, 32'h66, 32'd0);
        tick();
        chk("srl_bad_illegal", {31'd0, out_illegal}, 32'd1);
        chk("srl_bad_we", {31'd0, out_we}, 32'd0);
        chk("srl_bad_illcnt", illegal_count, 32'd1);

        // ADD x0,x1,x2: legal but no write-back
        drive(r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0), 32'd1, 32'd2, 32'd0);
        tick();
        chk("addx0_illegal", {31'd0, out_illegal}, 32'd0);
        chk("addx0_we", {31'd0, out_we}, 32'd0);
        chk("addx0_illcnt", illegal_count, 32'd2);
        chk("addx0_issue", issue_count, 32'd10);

        in_valid = 1'b0;
        tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_issue", issue_count, 32'd11);
        chk("drain_illcnt", illegal_count, 32'd2);

        // OR x12 then flush while stalled with a new bundle offered
        in_valid = 1'b1;
        drive(r_type(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd12), 32'd3, 32'd4, 32'd0);
        tick();
        chk("or_code", code(), 32'b00001);
        out_ready = 1'b0; flush = 1'b1;
        drive(r_type(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd13), 32'd3, 32'd4, 32'd0);
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_issue", issue_count, 32'd11);
        chk("flush_code_held", code(), 32'b00001);
        flush = 1'b0; out_ready = 1'b1;

        // AND x13, then flush concurrent with handoff: handoff still counts
        drive(r_type(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd13), 32'd3, 32'd4, 32'd0);
        tick();
        chk("and_code", code(), 32'b00000);
        chk("and_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        tick();
        chk("flush_ho_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ho_issue", issue_count, 32'd12);
        flush = 1'b0;

        // Reset during a stall
        drive(r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd14), 32'd9, 32'd8, 32'd0);
        tick();
        out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_code", code(), 32'b01010);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_srca", SrcA, 32'd0);
        chk("mid_rst_srcb", SrcB, 32'd0);
        chk("mid_rst_code", code(), 32'd0);
        chk("mid_rst_rd", {27'd0, out_rd}, 32'd0);
        chk("mid_rst_issue", issue_count, 32'd0);
        chk("mid_rst_illcnt", illegal_count, 32'd0);
        reset = 1'b0; in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
